spi_readback_tx: RTL and testbench
==================================

Name: spi_readback_tx

Overview:
Transmit side of the channel-register SPI path: serializes register contents back to the SPI master on MISO. On a read request it maps the 7-bit address to a channel index and a per-channel register select, covering the 56 channel-based addresses as 8 channels x 7 registers. It then fetches the byte from the register readback mux and shifts it out MSB first. It sits beside the address decoder in the SPI slave, clocked by spi_clk.

Parameters:
CH_REG_START_ADDR, 12, first channel-based register address
CH_REG_STOP_ADDR, 67, last channel-based register address
REGS_PER_CH, 7, registers per channel
DATA_W, 8, readback word width (bits shifted per read)

Ports:
spi_clk  input  1  SPI clock; all state on posedge
rst  input  1  asynchronous, active-high reset
cs  input  1  chip select, active-high; low aborts any read
rd_start  input  1  one-cycle read request; addr valid in same cycle
addr  input  7  register address to read
ch_sel  output  3  channel index to readback mux
reg_sel  output  3  per-channel register select (7 = none/global)
glob_sel  output  1  high when addr is outside channel range (global register path)
rd_data  input  DATA_W  readback byte; valid the cycle after selects are driven
miso  output  1  serial data out, MSB first
miso_oe  output  1  MISO output enable
busy  output  1  high from accepted rd_start until last bit shifted
done  output  1  one-cycle pulse after last bit

Behaviour:
- Reset (rst high, async): state IDLE; ch_sel=0, reg_sel=7, glob_sel=0, miso=0, miso_oe=0, busy=0, done=0, shift reg=0, bit counter=0.
- Decode is registered on rd_start, with a 1-cycle latency.
  - CH_REG_START_ADDR <= addr <= CH_REG_STOP_ADDR: off = addr-12, ch_sel = off/7, reg_sel = off%7, glob_sel = 0.
  - Otherwise: ch_sel = 0, reg_sel = 7, glob_sel = 1.
  - Arithmetic is unsigned, 7-bit; divide/modulo by constant.
  - Boundaries: addr 12 -> ch 0, reg 0; addr 18 -> ch 0, reg 6; addr 19 -> ch 1, reg 0; addr 67 -> ch 7, reg 6; addr 11 and 68 -> global.
- States:
  - IDLE: rd_start && cs -> FETCH; latch decoded selects; busy=1.
  - FETCH: selects stable; rd_data settles -> LOAD.
  - LOAD: shift reg <= rd_data; miso_oe=1; miso = rd_data[DATA_W-1] registered; counter=DATA_W-1 -> SHIFT.
  - SHIFT: each cycle shift left by 1, miso = next bit, counter decrements. When counter==0 and final bit has been presented one cycle -> IDLE with done=1 for one cycle, busy=0, miso_oe=0, miso=0.
- Latency: first bit (MSB) on miso 3 cycles after rd_start; last bit (LSB) at cycle 3+DATA_W-1; done in the following cycle.
- ch_sel/reg_sel/glob_sel hold their values until the next accepted rd_start; they return to reset values only on rst or cs abort.
- rd_start while busy: ignored, with no effect on the current transfer.
- cs low in any state: synchronous abort next posedge -> IDLE, miso_oe=0, miso=0, busy=0, done not asserted; selects return to reset values.
- rd_start with cs low: ignored.
- rst mid-transfer: immediate return to reset values; no done.
- rd_start coinciding with the done cycle: accepted (IDLE already entered).

Decomposition:
- Shared package spi_pkg holds:
  - constants CH_REG_START_ADDR, CH_REG_STOP_ADDR, REGS_PER_CH, NUM_CH=8, REG_SEL_NONE=3'd7;
  - enum tx_state_t {IDLE, FETCH, LOAD, SHIFT}.
- One sub-module: spi_addr_to_ch_reg (combinational addr -> ch_sel/reg_sel/glob_sel). It is reused by the write path for consistency.

Test Plan:
- rd_start, addr=12, rd_data=0xA5 -> ch_sel=0, reg_sel=0, glob_sel=0; miso 1,0,1,0,0,1,0,1 on cycles 3..10; done at cycle 11.
- addr=67, rd_data=0x3C -> ch_sel=7, reg_sel=6; miso 0,0,1,1,1,1,0,0.
- addr=11, then addr=68 -> reg_sel=7, ch_sel=0, glob_sel=1; byte shifted unchanged from rd_data.
- cs dropped after 4th bit -> next cycle miso_oe=0, busy=0; no done; reg_sel=7.
- Second rd_start while busy (addr=40) -> ignored; current byte completes; selects unchanged.
- rst pulsed during SHIFT -> all outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and state type for the SPI channel-register path
package spi_pkg;
  localparam logic [6:0] CH_REG_START_ADDR = 7'd12;
  localparam logic [6:0] CH_REG_STOP_ADDR = 7'd67;
  localparam logic [6:0] REGS_PER_CH = 7'd7;
  localparam int NUM_CH = 8;
  localparam logic [2:0] REG_SEL_NONE = 3'd7;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} tx_state_t;
endpackage

// File: rtl/spi_addr_to_ch_reg.sv
// spi_addr_to_ch_reg: maps a register address to channel/register selects or the global path
module spi_addr_to_ch_reg
  import spi_pkg::*;
(
  input  logic [6:0] addr,
  output logic [2:0] ch_sel,
  output logic [2:0] reg_sel,
  output logic       glob_sel
);
  logic [6:0] off;
  // addresses inside the channel window split into channel and register by constant divide
  always_comb begin
    off = addr - CH_REG_START_ADDR;
    glob_sel = (addr < CH_REG_START_ADDR) || (addr > CH_REG_STOP_ADDR);
    ch_sel = glob_sel ? 3'd0 : 3'(off / REGS_PER_CH);
    reg_sel = glob_sel ? REG_SEL_NONE : 3'(off % REGS_PER_CH);
  end
endmodule

// File: rtl/spi_readback_tx.sv
// spi_readback_tx: fetches a selected register byte and shifts it out on MISO, MSB first
module spi_readback_tx
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rd_start,
  input  logic [6:0]        addr,
  output logic [2:0]        ch_sel,
  output logic [2:0]        reg_sel,
  output logic              glob_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(DATA_W);
  tx_state_t state, state_d;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [2:0] dec_ch, dec_reg;
  logic dec_glob, accept, fin;
  spi_addr_to_ch_reg u_dec (
    .addr     (addr),
    .ch_sel   (dec_ch),
    .reg_sel  (dec_reg),
    .glob_sel (dec_glob)
  );
  // state register
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  // next state and status; dropping cs forces IDLE from anywhere
  always_comb begin
    state_d = state;
    accept = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: begin
        accept = cs && rd_start;
        state_d = accept ? FETCH : IDLE;
      end
      FETCH: state_d = LOAD;
      LOAD: state_d = SHIFT;
      SHIFT: begin
        fin = cs && (cnt == '0);
        state_d = (cnt == '0) ? IDLE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
    if (!cs) state_d = IDLE;
    busy = (state != IDLE);
    miso_oe = (state == SHIFT);
  end
  // selects, shift register, bit counter, miso and done pulse
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      ch_sel <= 3'd0;
      reg_sel <= REG_SEL_NONE;
      glob_sel <= 1'b0;
      shreg <= '0;
      cnt <= '0;
      miso <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (!cs) begin
        ch_sel <= 3'd0;
        reg_sel <= REG_SEL_NONE;
        glob_sel <= 1'b0;
        shreg <= '0;
        cnt <= '0;
        miso <= 1'b0;
      end else if (accept) begin
        ch_sel <= dec_ch;
        reg_sel <= dec_reg;
        glob_sel <= dec_glob;
      end else if (state == LOAD) begin
        shreg <= rd_data;
        miso <= rd_data[DATA_W-1];
        cnt <= CW'(DATA_W - 1);
      end else if (state == SHIFT) begin
        shreg <= shreg << 1;
        miso <= (cnt == '0) ? 1'b0 : shreg[DATA_W-2];
        cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_readback_tx.sv
// tb_spi_readback_tx: randomized and directed reads checked against an address/byte reference model
module tb_spi_readback_tx;
  logic clk = 1'b0;
  logic rst, cs, rd_start;
  logic [6:0] addr;
  logic [2:0] ch_sel, reg_sel;
  logic glob_sel, miso, miso_oe, busy, done;
  logic [7:0] rd_data;
  logic [7:0] mem [0:63];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  assign rd_data = mem[{ch_sel, reg_sel}];
  spi_readback_tx #(.DATA_W(8)) dut (
    .spi_clk  (clk),
    .rst      (rst),
    .cs       (cs),
    .rd_start (rd_start),
    .addr     (addr),
    .ch_sel   (ch_sel),
    .reg_sel  (reg_sel),
    .glob_sel (glob_sel),
    .rd_data  (rd_data),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .busy     (busy),
    .done     (done)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_ch"}, 8'(ch_sel), 8'd0);
    chk({tag, "_reg"}, 8'(reg_sel), 8'd7);
    chk({tag, "_glob"}, 8'(glob_sel), 8'd0);
    chk({tag, "_miso"}, 8'(miso), 8'd0);
    chk({tag, "_oe"}, 8'(miso_oe), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_done"}, 8'(done), 8'd0);
  endtask
  task automatic do_read(input logic [6:0] a, input bit inject);
    int off;
    logic eg;
    logic [2:0] ec, er;
    logic [7:0] eb;
    off = int'(a) - 12;
    eg = (off < 0) || (off > 55);
    ec = eg ? 3'd0 : 3'(off / 7);
    er = eg ? 3'd7 : 3'(off % 7);
    eb = mem[{ec, er}];
    rd_start = 1'b1;
    addr = a;
    @(negedge clk);
    rd_start = 1'b0;
    chk("sel_ch", 8'(ch_sel), 8'(ec));
    chk("sel_reg", 8'(reg_sel), 8'(er));
    chk("sel_glob", 8'(glob_sel), 8'(eg));
    chk("busy_start", 8'(busy), 8'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("miso_bit", 8'(miso), 8'(eb[7-i]));
      chk("miso_oe", 8'(miso_oe), 8'd1);
      chk("done_early", 8'(done), 8'd0);
      if (inject && i == 2) begin
        rd_start = 1'b1;
        addr = 7'd40;
      end
      @(negedge clk);
      rd_start = 1'b0;
    end
    chk("done", 8'(done), 8'd1);
    chk("busy_end", 8'(busy), 8'd0);
    chk("oe_end", 8'(miso_oe), 8'd0);
    chk("miso_end", 8'(miso), 8'd0);
    chk("hold_ch", 8'(ch_sel), 8'(ec));
    chk("hold_reg", 8'(reg_sel), 8'(er));
    chk("hold_glob", 8'(glob_sel), 8'(eg));
  endtask
  initial begin
    logic [7:0] eb;
    rst = 1'b1;
    cs = 1'b0;
    rd_start = 1'b0;
    addr = 7'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[{3'd0, 3'd0}] = 8'hA5;
    mem[{3'd7, 3'd6}] = 8'h3C;
    #1;
    chk_idle("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cs = 1'b1;
    @(negedge clk);
    do_read(7'd12, 1'b0);
    do_read(7'd67, 1'b0);
    do_read(7'd18, 1'b0);
    do_read(7'd19, 1'b0);
    do_read(7'd11, 1'b0);
    do_read(7'd68, 1'b0);
    do_read(7'd20, 1'b1);
    eb = mem[{3'd2, 3'd4}];
    rd_start = 1'b1;
    addr = 7'd30;
    @(negedge clk);
    rd_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_bit4", 8'(miso), 8'(eb[4]));
    cs = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    @(negedge clk);
    chk("abort_nodone", 8'(done), 8'd0);
    cs = 1'b1;
    @(negedge clk);
    rd_start = 1'b1;
    addr = 7'd50;
    @(negedge clk);
    rd_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_oe", 8'(miso_oe), 8'd1);
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 8'(done), 8'd0);
    repeat (20) do_read(7'($urandom_range(0, 127)), 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
